// File: rtl/temporizador_jogada_pkg.sv
// temporizador_jogada_pkg
// Shared definitions for the play/measurement timeout supervisor:
//   - estado_t   : FSM state encoding (OCIOSO, CONTANDO, ESGOTADO)
//   - largura_ok : elaboration-time check that a W-bit count can hold N_TICKS
package temporizador_jogada_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    CONTANDO = 2'b01,
    ESGOTADO = 2'b10
  } estado_t;

  // The count must reach N_TICKS itself (saturated value in ESGOTADO).
  function automatic bit largura_ok(int w, int n_ticks);
    return (2 ** w) > n_ticks;
  endfunction

endpackage

// File: rtl/temporizador_jogada_if.sv
// temporizador_jogada_if
// Bundles the control/handshake signals between the parent FSM, the upstream
// modulo-M tick counter and the timeout supervisor.
//   slave  modport : the supervisor (consumes iniciar/parar/tick[/pausa],
//                    drives conta_tick/zera_tick/ticks/ativo/aviso/esgotado/timeout)
//   master modport : the surrounding logic (the opposite directions)
// Optional macro TEMPORIZADOR_PAUSA_EN adds the pausa signal.
interface temporizador_jogada_if #(
  parameter int W = 3
);
  logic         iniciar;
  logic         parar;
  logic         tick;
`ifdef TEMPORIZADOR_PAUSA_EN
  logic         pausa;
`endif
  logic         conta_tick;
  logic         zera_tick;
  logic [W-1:0] ticks;
  logic         ativo;
  logic         aviso;
  logic         esgotado;
  logic         timeout;

`ifdef TEMPORIZADOR_PAUSA_EN
  modport slave (
    input  iniciar, parar, tick, pausa,
    output conta_tick, zera_tick, ticks, ativo, aviso, esgotado, timeout
  );
  modport master (
    output iniciar, parar, tick, pausa,
    input  conta_tick, zera_tick, ticks, ativo, aviso, esgotado, timeout
  );
`else
  modport slave (
    input  iniciar, parar, tick,
    output conta_tick, zera_tick, ticks, ativo, aviso, esgotado, timeout
  );
  modport master (
    output iniciar, parar, tick,
    input  conta_tick, zera_tick, ticks, ativo, aviso, esgotado, timeout
  );
`endif
endinterface

// File: rtl/temporizador_jogada.sv
// temporizador_jogada
// Timeout supervisor downstream of a modulo-M tick counter. Counts N_TICKS
// tick pulses per armed interval, raises aviso from AVISO ticks on, and emits
// a one-cycle timeout pulse on expiry.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : temporizador_jogada_if.slave
//           in : iniciar (arm/restart), parar (disarm), tick (counter fim)
//                [pausa when TEMPORIZADOR_PAUSA_EN is defined]
//           out: conta_tick, zera_tick (upstream counter controls), ticks,
//                ativo, aviso, esgotado, timeout
// Optional macro TEMPORIZADOR_PAUSA_EN: freezes counting while pausa=1.
//
// state    | meaning
// OCIOSO   | disarmed; upstream counter held clear
// CONTANDO | counting ticks of the armed interval
// ESGOTADO | interval expired; waits for iniciar or parar
import temporizador_jogada_pkg::*;

module temporizador_jogada #(
  parameter int N_TICKS = 5,
  parameter int AVISO   = 3,
  parameter int W       = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  temporizador_jogada_if.slave  bus
);

  localparam bit WIDTH_OK = largura_ok(W, N_TICKS);

  generate
    if (!WIDTH_OK) begin : g_width_check
      $error("temporizador_jogada: W too small to hold N_TICKS");
    end
  endgenerate

  localparam logic [W-1:0] ULTIMO   = W'(N_TICKS - 1);
  localparam logic [W-1:0] SATURADO = W'(N_TICKS);
  localparam logic [W-1:0] LIMIAR   = W'(AVISO);

  estado_t      estado, estado_nxt;
  logic [W-1:0] ticks_q, ticks_nxt;
  logic         timeout_q, timeout_nxt;
  logic         pausa_ef;

`ifdef TEMPORIZADOR_PAUSA_EN
  assign pausa_ef = bus.pausa;
`else
  assign pausa_ef = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      ticks_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      estado    <= estado_nxt;
      ticks_q   <= ticks_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    estado_nxt  = estado;
    ticks_nxt   = ticks_q;
    timeout_nxt = 1'b0;
    case (estado)
      OCIOSO: begin
        if (bus.iniciar) begin
          estado_nxt = CONTANDO;
          ticks_nxt  = '0;
        end
      end
      CONTANDO: begin
        // parar beats tick (and pausa); ticks kept on stop for readout
        if (bus.parar) begin
          estado_nxt = OCIOSO;
        end else if (bus.tick && !pausa_ef) begin
          if (ticks_q == ULTIMO) begin
            estado_nxt  = ESGOTADO;
            ticks_nxt   = SATURADO;
            timeout_nxt = 1'b1;
          end else begin
            ticks_nxt = ticks_q + 1'b1;
          end
        end
      end
      ESGOTADO: begin
        if (bus.parar) begin
          estado_nxt = OCIOSO;
        end else if (bus.iniciar) begin
          estado_nxt = CONTANDO;
          ticks_nxt  = '0;
        end
      end
      default: begin
        estado_nxt = OCIOSO;
        ticks_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    bus.zera_tick  = (estado != CONTANDO);
    bus.conta_tick = (estado == CONTANDO) && !pausa_ef;
    bus.ativo      = (estado == CONTANDO);
    bus.esgotado   = (estado == ESGOTADO);
    bus.aviso      = (estado == CONTANDO) && (ticks_q >= LIMIAR);
    bus.ticks      = ticks_q;
    bus.timeout    = timeout_q;
  end

endmodule
